// File: rtl/fifo_unpacker.sv
// FIFO read-side unpacker: pops 64-bit words and streams them out
// as CHUNK_W-bit chunks, LSB first, with a one-word prefetch buffer.
module fifo_unpacker #(
    parameter int CHUNK_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        fifo_data,
    input  logic               fifo_data_valid,
    input  logic               fifo_empty,
    output logic               pop_fifo,
    output logic [CHUNK_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               err
);

    localparam int NCHUNK = 64 / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    logic [63:0]      sreg_q, sreg_d;
    logic [63:0]      pbuf_q, pbuf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             pbuf_full_q, pbuf_full_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;

    logic arrival;
    logic spurious;
    logic hs;
    logic is_last;
    logic sreg_free;

    assign arrival   = fifo_data_valid && pend_q;
    assign spurious  = fifo_data_valid && !pend_q;
    assign hs        = out_valid_q && out_ready;
    assign is_last   = (cnt_q == LAST_IDX);
    assign sreg_free = !out_valid_q || (hs && is_last);

    assign pop_fifo  = !rst && !fifo_empty && !pend_q && !pbuf_full_q;
    assign out_data  = sreg_q[CHUNK_W-1:0];
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && is_last;
    assign err       = err_q;

    always_comb begin
        sreg_d      = sreg_q;
        pbuf_d      = pbuf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        pbuf_full_d = pbuf_full_q;
        pend_d      = pend_q;
        err_d       = err_q | spurious;

        if (pop_fifo) begin
            pend_d = 1'b1;
        end else if (arrival) begin
            pend_d = 1'b0;
        end

        if (hs) begin
            if (!is_last) begin
                sreg_d = sreg_q >> CHUNK_W;
                cnt_d  = cnt_q + 1'b1;
            end else if (pbuf_full_q) begin
                sreg_d      = pbuf_q;
                pbuf_full_d = 1'b0;
                cnt_d       = '0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // pbuf is never full while a pop is pending, so an arrival
        // cannot collide with the pbuf-to-sreg transfer above.
        if (arrival) begin
            if (sreg_free) begin
                sreg_d      = fifo_data;
                cnt_d       = '0;
                out_valid_d = 1'b1;
            end else begin
                pbuf_d      = fifo_data;
                pbuf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q      <= '0;
            pbuf_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            pbuf_full_q <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            pbuf_q      <= pbuf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            pbuf_full_q <= pbuf_full_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

endmodule
